// File: rtl/mac_accumulator_pkg.sv
// Shared types and default widths for the MAC accumulation stage.
// Imported by the interface, the adder and the top-level FSM.
package mac_accumulator_pkg;

  localparam int DEF_PROD_W = 32;
  localparam int DEF_ACC_W  = 40;
  localparam int DEF_LEN_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/mac_accumulator_if.sv
// Product-in / result-out handshake bundle between the multiplier, the
// accumulator (slave) and the next layer stage (master side drives inputs).
interface mac_accumulator_if
  import mac_accumulator_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int ACC_W  = DEF_ACC_W
);

  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] prod;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  acc_out;
  logic              ovf;

  modport master (
    output in_valid,
    output prod,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  acc_out,
    input  ovf
  );

  modport slave (
    input  in_valid,
    input  prod,
    input  out_ready,
    output in_ready,
    output out_valid,
    output acc_out,
    output ovf
  );

endinterface

// File: rtl/mac_accumulator_add.sv
// Combinational accumulate step: zero-extended product plus accumulator with
// carry out. Saturation to all-ones is enabled by defining MAC_ACC_SAT_EN.
module mac_accumulator_add
  import mac_accumulator_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic [ACC_W-1:0]  i_acc,
  input  logic [PROD_W-1:0] i_prod,
  output logic [ACC_W-1:0]  o_sum,
  output logic              o_carry
);

  logic [ACC_W:0] w_sum_ext;
  logic [ACC_W:0] w_prod_ext;

  assign w_prod_ext = (ACC_W+1)'(i_prod);
  assign w_sum_ext  = {1'b0, i_acc} + w_prod_ext;
  assign o_carry    = w_sum_ext[ACC_W];

`ifdef MAC_ACC_SAT_EN
  // Once clamped, any further nonzero add carries again and stays clamped.
  assign o_sum = o_carry ? {ACC_W{1'b1}} : w_sum_ext[ACC_W-1:0];
`else
  assign o_sum = w_sum_ext[ACC_W-1:0];
`endif

endmodule

// File: rtl/mac_accumulator.sv
// Dot-product accumulator: sums len products from the multiplier and hands the
// result downstream. Saturating arithmetic is selected by MAC_ACC_SAT_EN.
//
// state    | meaning
// ST_IDLE  | waiting for start; acc holds the previous result
// ST_ACCUM | accepting one product per cycle until len beats are summed
// ST_DONE  | result valid on acc_out until out_ready
module mac_accumulator
  import mac_accumulator_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len,
  output logic             o_busy,
  mac_accumulator_if.slave bus
);

  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] r_len_q;
  logic             r_ovf;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;

  logic [ACC_W-1:0] w_sum;
  logic             w_carry;
  logic             w_accept;
  logic             w_last;

  mac_accumulator_add #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_add (
    .i_acc   (r_acc),
    .i_prod  (bus.prod),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  assign w_accept = bus.in_valid & r_in_ready;
  // len_q is never zero in ACCUM, so the subtraction cannot underflow here.
  assign w_last   = (r_cnt == (r_len_q - LEN_W'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_len_q     <= '0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
            r_len_q <= i_len;
            r_busy  <= 1'b1;
            if (i_len == '0) begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
            end else begin
              r_state    <= ST_ACCUM;
              r_in_ready <= 1'b1;
            end
          end
        end

        ST_ACCUM: begin
          if (w_accept) begin
            r_acc <= w_sum;
            r_ovf <= r_ovf | w_carry;
            r_cnt <= r_cnt + LEN_W'(1);
            if (w_last) begin
              r_state     <= ST_DONE;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end
        end

        ST_DONE: begin
          // A start coinciding with out_ready is dropped; only IDLE samples it.
          if (bus.out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.acc_out   = r_acc;
  assign bus.ovf       = r_ovf;
  assign o_busy        = r_busy;

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator: 40-bit instance for sums and handshakes,
// 33-bit instance for overflow behaviour (expectation follows MAC_ACC_SAT_EN).
module tb_mac_accumulator;

  localparam int PW  = 32;
  localparam int AW  = 40;
  localparam int AW2 = 33;
  localparam int LW  = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          start, start2;
  logic [LW-1:0] len, len2;
  logic          busy, busy2;

  mac_accumulator_if #(.PROD_W(PW), .ACC_W(AW))  b ();
  mac_accumulator_if #(.PROD_W(PW), .ACC_W(AW2)) b2 ();

  mac_accumulator #(.PROD_W(PW), .ACC_W(AW), .LEN_W(LW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (start),
    .i_len   (len),
    .o_busy  (busy),
    .bus     (b)
  );

  mac_accumulator #(.PROD_W(PW), .ACC_W(AW2), .LEN_W(LW)) dut33 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (start2),
    .i_len   (len2),
    .o_busy  (busy2),
    .bus     (b2)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] q_prod[$];

  // Start a dot product on the main instance and feed q_prod with in_valid high.
  task automatic run_dot(input string nm, input logic [LW-1:0] n,
                         output int lat, output bit saw_rdy);
    int idx;
    bit rdy;
    idx     = 0;
    saw_rdy = 0;
    start   = 1'b1;
    len     = n;
    tick();
    start = 1'b0;
    len   = '0;
    lat   = 1;
    while (!b.out_valid && lat < 600) begin
      if (b.in_ready) saw_rdy = 1;
      b.in_valid = (idx < q_prod.size());
      b.prod     = (idx < q_prod.size()) ? q_prod[idx] : '0;
      rdy        = b.in_ready;
      @(posedge clk);
      if (b.in_valid && rdy) idx++;
      #1;
      lat++;
    end
    if (b.in_ready) saw_rdy = 1;
    b.in_valid = 1'b0;
    b.prod     = '0;
    if (!b.out_valid) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s timeout: out_valid never rose", nm);
    end
  endtask

  task automatic finish_dot(input string nm);
    b.out_ready = 1'b1;
    tick();
    b.out_ready = 1'b0;
    chk({nm, " out_valid drop"}, 64'(b.out_valid), 64'd0);
    chk({nm, " busy drop"}, 64'(busy), 64'd0);
  endtask

  typedef struct {
    logic [LW-1:0] n;
    logic [31:0]   p[4];
    logic [63:0]   exp_acc;
    logic          exp_ovf;
    int            exp_lat;
  } vec_t;

  vec_t tbl[5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    bit          saw;
    int          c;
    logic [63:0] ref_sum;
    logic [15:0] a, m;
    logic [31:0] p;
    logic [63:0] exp33;

    tbl[0] = '{8'd3, '{32'd10, 32'd20, 32'd30, 32'd0}, 64'd60, 1'b0, 4};
    tbl[1] = '{8'd0, '{32'd0, 32'd0, 32'd0, 32'd0}, 64'd0, 1'b0, 1};
    tbl[2] = '{8'd1, '{32'd7, 32'd0, 32'd0, 32'd0}, 64'd7, 1'b0, 2};
    tbl[3] = '{8'd4, '{32'd1, 32'd2, 32'd3, 32'd4}, 64'd10, 1'b0, 5};
    tbl[4] = '{8'd2, '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0}, 64'h1_FFFF_FFFE, 1'b0, 3};

    rst_n = 1'b0;
    start = 1'b0; len = '0; start2 = 1'b0; len2 = '0;
    b.in_valid = 1'b0; b.prod = '0; b.out_ready = 1'b0;
    b2.in_valid = 1'b0; b2.prod = '0; b2.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst in_ready", 64'(b.in_ready), 64'd0);
    chk("rst out_valid", 64'(b.out_valid), 64'd0);
    chk("rst ovf", 64'(b.ovf), 64'd0);
    chk("rst acc_out", 64'(b.acc_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Table vectors, issued back-to-back: each start lands right after a handshake.
    for (int i = 0; i < 5; i++) begin
      q_prod.delete();
      for (int k = 0; k < int'(tbl[i].n); k++) q_prod.push_back(tbl[i].p[k]);
      run_dot($sformatf("vec%0d", i), tbl[i].n, lat, saw);
      chk($sformatf("vec%0d acc_out", i), 64'(b.acc_out), tbl[i].exp_acc);
      chk($sformatf("vec%0d ovf", i), 64'(b.ovf), 64'(tbl[i].exp_ovf));
      chk($sformatf("vec%0d latency", i), 64'(lat), 64'(tbl[i].exp_lat));
      chk($sformatf("vec%0d in_ready seen", i), 64'(saw), 64'(tbl[i].n != 0));
      finish_dot($sformatf("vec%0d", i));
    end

    // Gaps between beats, then a stalled consumer.
    start = 1'b1; len = 8'd2;
    tick();
    start = 1'b0;
    b.in_valid = 1'b1; b.prod = 32'd100;
    tick();
    b.in_valid = 1'b0;
    repeat (3) begin
      chk("gap in_ready", 64'(b.in_ready), 64'd1);
      tick();
    end
    b.in_valid = 1'b1; b.prod = 32'd250;
    tick();
    b.in_valid = 1'b1; b.prod = 32'd1;
    chk("gap out_valid", 64'(b.out_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      chk("stall acc_out", 64'(b.acc_out), 64'd350);
      chk("stall out_valid", 64'(b.out_valid), 64'd1);
      chk("stall in_ready", 64'(b.in_ready), 64'd0);
      tick();
    end
    // out_ready and start together: handshake completes, no new operation.
    b.in_valid = 1'b0;
    b.out_ready = 1'b1; start = 1'b1; len = 8'd3;
    tick();
    b.out_ready = 1'b0; start = 1'b0; len = '0;
    chk("handshake out_valid", 64'(b.out_valid), 64'd0);
    chk("start+out_ready busy", 64'(busy), 64'd0);
    b.in_valid = 1'b1; b.prod = 32'd5;
    tick();
    tick();
    b.in_valid = 1'b0;
    chk("idle busy", 64'(busy), 64'd0);
    chk("idle in_valid ignored", 64'(b.acc_out), 64'd350);

    // start during ACCUM must neither restart nor resample len.
    start = 1'b1; len = 8'd2;
    tick();
    start = 1'b1; len = 8'd0;
    b.in_valid = 1'b1; b.prod = 32'd3;
    tick();
    start = 1'b0;
    b.prod = 32'd4;
    tick();
    b.in_valid = 1'b0;
    chk("ignored start out_valid", 64'(b.out_valid), 64'd1);
    chk("ignored start acc_out", 64'(b.acc_out), 64'd7);
    finish_dot("ignored start");

    // Reset mid-operation.
    start = 1'b1; len = 8'd4;
    tick();
    start = 1'b0;
    b.in_valid = 1'b1; b.prod = 32'd5;
    tick();
    b.prod = 32'd6;
    tick();
    b.in_valid = 1'b0;
    chk("pre-reset acc_out", 64'(b.acc_out), 64'd11);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst acc_out", 64'(b.acc_out), 64'd0);
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst in_ready", 64'(b.in_ready), 64'd0);
    chk("midrst out_valid", 64'(b.out_valid), 64'd0);
    chk("midrst ovf", 64'(b.ovf), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    q_prod.delete();
    q_prod.push_back(32'd7);
    run_dot("post-reset", 8'd1, lat, saw);
    chk("post-reset acc_out", 64'(b.acc_out), 64'd7);
    chk("post-reset latency", 64'(lat), 64'd2);
    finish_dot("post-reset");

    // Overflow on the 33-bit instance.
`ifdef MAC_ACC_SAT_EN
    exp33 = 64'h1_FFFF_FFFF;
`else
    exp33 = 64'h0_FFFF_FFFD;
`endif
    start2 = 1'b1; len2 = 8'd3;
    tick();
    start2 = 1'b0;
    b2.in_valid = 1'b1; b2.prod = 32'hFFFF_FFFF;
    c = 1;
    while (!b2.out_valid && c < 50) begin
      tick();
      c++;
    end
    b2.in_valid = 1'b0;
    chk("ovf33 latency", 64'(c), 64'd4);
    chk("ovf33 acc_out", 64'(b2.acc_out), exp33);
    chk("ovf33 ovf", 64'(b2.ovf), 64'd1);
    tick();
    chk("ovf33 stall acc_out", 64'(b2.acc_out), exp33);
    chk("ovf33 stall ovf", 64'(b2.ovf), 64'd1);
    b2.out_ready = 1'b1;
    tick();
    b2.out_ready = 1'b0;
    chk("ovf33 idle ovf held", 64'(b2.ovf), 64'd1);
    start2 = 1'b1; len2 = 8'd1;
    tick();
    start2 = 1'b0;
    chk("ovf33 cleared on start", 64'(b2.ovf), 64'd0);
    b2.in_valid = 1'b1; b2.prod = 32'd1;
    tick();
    b2.in_valid = 1'b0;
    chk("ovf33 small acc_out", 64'(b2.acc_out), 64'd1);
    chk("ovf33 small ovf", 64'(b2.ovf), 64'd0);
    b2.out_ready = 1'b1;
    tick();
    b2.out_ready = 1'b0;

    // Products from the 16x16 multiplier, including the largest product.
    q_prod.delete();
    ref_sum = '0;
    for (int i = 0; i < 16; i++) begin
      if (i == 0) begin
        a = 16'hFFFF; m = 16'hFFFF;
      end else begin
        a = 16'($urandom_range(0, 65535));
        m = 16'($urandom_range(0, 65535));
      end
      p = 32'(a) * 32'(m);
      q_prod.push_back(p);
      ref_sum = ref_sum + 64'(p);
    end
    run_dot("mult", 8'd16, lat, saw);
    chk("mult acc_out", 64'(b.acc_out), ref_sum);
    chk("mult ovf", 64'(b.ovf), 64'd0);
    chk("mult latency", 64'(lat), 64'd17);
    finish_dot("mult");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
